// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin front-end for the single-port data RAM.
// Same-cycle grant, one-cycle response, out-of-window requests answered with an error.
module sp_ram_arbiter #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  output logic                    a_rvalid_o,
  input  logic [31:0]             a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  output logic                    b_rvalid_o,
  input  logic [31:0]             b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    ram_bypass_en_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e                 last_gnt_q, last_gnt_d;
  logic [1:0]            resp_vld_q, resp_vld_d;
  logic [1:0]            resp_err_q, resp_err_d;
  logic [1:0]            resp_rd_q,  resp_rd_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  logic                  a_hit, b_hit, gnt_a, gnt_b;
  logic                  sel_hit, sel_we;
  logic [DATA_WIDTH-1:0] a_resp_data, b_resp_data;

  // Window decode and round-robin grant: the port not granted last wins a tie.
  always_comb begin
    a_hit = (a_addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    b_hit = (b_addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    gnt_a = a_req_i && (!b_req_i || (last_gnt_q == PORT_B));
    gnt_b = b_req_i && (!a_req_i || (last_gnt_q == PORT_A));
  end

  // RAM request mux; port A drives addr/wdata whenever B is not granted.
  always_comb begin
    sel_hit         = gnt_b ? b_hit : (gnt_a && a_hit);
    sel_we          = gnt_b ? b_we_i : a_we_i;
    ram_en_o        = sel_hit;
    ram_addr_o      = gnt_b ? b_addr_i[ADDR_WIDTH-1:0] : a_addr_i[ADDR_WIDTH-1:0];
    ram_wdata_o     = gnt_b ? b_wdata_i : a_wdata_i;
    ram_we_o        = sel_hit && sel_we;
    ram_be_o        = sel_hit ? (gnt_b ? b_be_i : a_be_i) : BE_W'(0);
    ram_bypass_en_o = 1'b0;
    a_gnt_o         = gnt_a;
    b_gnt_o         = gnt_b;
  end

  // Response next-state: flag set one cycle after grant, read data latched during read responses.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    resp_vld_d  = {gnt_b, gnt_a};
    resp_err_d  = {gnt_b && !b_hit, gnt_a && !a_hit};
    resp_rd_d   = {gnt_b && !b_we_i, gnt_a && !a_we_i};
    a_resp_data = resp_err_q[0] ? DATA_WIDTH'(0) : ram_rdata_i;
    b_resp_data = resp_err_q[1] ? DATA_WIDTH'(0) : ram_rdata_i;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    if (gnt_a) last_gnt_d = PORT_A;
    if (gnt_b) last_gnt_d = PORT_B;
    if (resp_vld_q[0] && resp_rd_q[0]) a_rdata_d = a_resp_data;
    if (resp_vld_q[1] && resp_rd_q[1]) b_rdata_d = b_resp_data;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt_q <= PORT_B;
      resp_vld_q <= 2'b00;
      resp_err_q <= 2'b00;
      resp_rd_q  <= 2'b00;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      resp_vld_q <= resp_vld_d;
      resp_err_q <= resp_err_d;
      resp_rd_q  <= resp_rd_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Live RAM data during a read response, otherwise the held value.
  always_comb begin
    a_rvalid_o = resp_vld_q[0];
    b_rvalid_o = resp_vld_q[1];
    a_err_o    = resp_vld_q[0] && resp_err_q[0];
    b_err_o    = resp_vld_q[1] && resp_err_q[1];
    a_rdata_o  = (resp_vld_q[0] && resp_rd_q[0]) ? a_resp_data : a_rdata_q;
    b_rdata_o  = (resp_vld_q[1] && resp_rd_q[1]) ? b_resp_data : b_rdata_q;
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM attached.
module tb_sp_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        a_req_i, a_gnt_o, a_rvalid_o, a_we_i, a_err_o;
  logic [31:0] a_addr_i, a_wdata_i, a_rdata_o;
  logic [3:0]  a_be_i;
  logic        b_req_i, b_gnt_o, b_rvalid_o, b_we_i, b_err_o;
  logic [31:0] b_addr_i, b_wdata_i, b_rdata_o;
  logic [3:0]  b_be_i;
  logic        ram_en_o, ram_we_o, ram_bypass_en_o;
  logic [14:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o, ram_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  sp_ram_arbiter dut (
    .clk(clk), .rstn_i(rstn_i),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_addr_i(a_addr_i),
    .a_we_i(a_we_i), .a_be_i(a_be_i), .a_wdata_i(a_wdata_i), .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_addr_i(b_addr_i),
    .b_we_i(b_we_i), .b_be_i(b_be_i), .b_wdata_i(b_wdata_i), .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_bypass_en_o(ram_bypass_en_o)
  );

  // Behavioural RAM: byte-enabled write, read data one cycle after enable.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int k = 0; k < 4; k++)
          if (ram_be_o[k]) mem[ram_addr_o[14:2]][8*k +: 8] <= ram_wdata_o[8*k +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[14:2]];
      end
    end
  end

  task automatic set_a(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata);
    a_req_i = req; a_addr_i = addr; a_we_i = we; a_be_i = be; a_wdata_i = wdata;
  endtask

  task automatic set_b(input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata);
    b_req_i = req; b_addr_i = addr; b_we_i = we; b_be_i = be; b_wdata_i = wdata;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_b(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, ram_en_o, ram_we_o, ram_be_o, ram_bypass_en_o} !== 13'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", {a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, ram_en_o, ram_we_o, ram_be_o, ram_bypass_en_o});
    end
    n_checks++;
    if (a_rdata_o !== 32'h0 || b_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got a=%h b=%h required 0", a_rdata_o, b_rdata_o);
    end
    rstn_i = 1'b1;
  endtask

  task automatic test_contention();
    logic exp_a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_a(1'b1, 32'h0010_0100, 1'b1, 4'hF, 32'hA0A0_0000);
      set_b(1'b1, 32'h0010_0200, 1'b1, 4'hF, 32'hB0B0_0000);
      exp_a = (i % 2 == 0);
      #1;
      n_checks++;
      if (a_gnt_o !== exp_a || b_gnt_o !== !exp_a) begin
        n_fail++; $display("FAIL contention_gnt[%0d]: got a=%b b=%b required a=%b b=%b", i, a_gnt_o, b_gnt_o, exp_a, !exp_a);
      end
      @(posedge clk); #1;
      n_checks++;
      if (a_rvalid_o !== exp_a || b_rvalid_o !== !exp_a || a_err_o !== 1'b0 || b_err_o !== 1'b0) begin
        n_fail++; $display("FAIL contention_rvalid[%0d]: got a=%b b=%b err=%b%b required a=%b b=%b err=00",
                           i, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, exp_a, !exp_a);
      end
    end
    @(negedge clk);
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_b(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_a(1'b1, 32'h0010_0040, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (a_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 15'h0040 || ram_wdata_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_write_req: got gnt=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 0040 deadbeef",
                         a_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o);
    end
    @(negedge clk);
    set_a(1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (a_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_we_o !== 1'b0 || a_rvalid_o !== 1'b1) begin
      n_fail++; $display("FAIL single_read_req: got gnt=%b en=%b we=%b wr_rvalid=%b required 1 1 0 1", a_gnt_o, ram_en_o, ram_we_o, a_rvalid_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_rvalid_o !== 1'b1 || a_rdata_o !== 32'hDEAD_BEEF || a_err_o !== 1'b0) begin
      n_fail++; $display("FAIL single_read_rsp: got rvalid=%b rdata=%h err=%b required 1 deadbeef 0", a_rvalid_o, a_rdata_o, a_err_o);
    end
    @(negedge clk);
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    #1;
    n_checks++;
    if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0 || ram_be_o !== 4'h0 || a_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_ram: got en=%b we=%b be=%h gnt=%b required 0 0 0 0", ram_en_o, ram_we_o, ram_be_o, a_gnt_o);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_rvalid_o !== 1'b0 || a_rdata_o !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL single_read_hold: got rvalid=%b rdata=%h required 0 deadbeef", a_rvalid_o, a_rdata_o);
      end
    end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    set_b(1'b1, 32'h0010_0080, 1'b1, 4'hF, 32'h1122_3344);
    @(negedge clk);
    set_b(1'b1, 32'h0010_0080, 1'b1, 4'b0010, 32'h0000_AB00);
    #1;
    n_checks++;
    if (b_gnt_o !== 1'b1 || ram_be_o !== 4'b0010 || ram_addr_o !== 15'h0080) begin
      n_fail++; $display("FAIL byte_write_req: got gnt=%b be=%b addr=%h required 1 0010 0080", b_gnt_o, ram_be_o, ram_addr_o);
    end
    @(negedge clk);
    set_b(1'b1, 32'h0010_0080, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (b_rvalid_o !== 1'b1 || b_rdata_o !== 32'h1122_AB44 || b_err_o !== 1'b0) begin
      n_fail++; $display("FAIL byte_write_readback: got rvalid=%b rdata=%h err=%b required 1 1122ab44 0", b_rvalid_o, b_rdata_o, b_err_o);
    end
    @(negedge clk);
    set_b(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (b_rvalid_o !== 1'b0 || b_rdata_o !== 32'h1122_AB44 || a_rdata_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL byte_write_hold: got rvalid=%b b_rdata=%h a_rdata=%h required 0 1122ab44 deadbeef", b_rvalid_o, b_rdata_o, a_rdata_o);
    end
  endtask

  task automatic test_out_of_window();
    @(negedge clk);
    set_a(1'b1, 32'h0020_0000, 1'b0, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (a_gnt_o !== 1'b1 || ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
      n_fail++; $display("FAIL oow_req: got gnt=%b en=%b we=%b required 1 0 0", a_gnt_o, ram_en_o, ram_we_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_rvalid_o !== 1'b1 || a_err_o !== 1'b1 || a_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL oow_rsp: got rvalid=%b err=%b rdata=%h required 1 1 0", a_rvalid_o, a_err_o, a_rdata_o);
    end
    @(negedge clk);
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (a_rvalid_o !== 1'b0 || a_err_o !== 1'b0 || a_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL oow_after: got rvalid=%b err=%b rdata=%h required 0 0 0", a_rvalid_o, a_err_o, a_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_a(1'b1, 32'h0010_0000 + 32'(4 * i), 1'b1, 4'hF, 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_a(1'b1, 32'h0010_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
      #1;
      n_checks++;
      if (a_gnt_o !== 1'b1 || ram_en_o !== 1'b1 || ram_addr_o !== 15'(4 * i)) begin
        n_fail++; $display("FAIL b2b_req[%0d]: got gnt=%b en=%b addr=%h required 1 1 %h", i, a_gnt_o, ram_en_o, ram_addr_o, 15'(4 * i));
      end
      @(posedge clk); #1;
      n_checks++;
      if (a_rvalid_o !== 1'b1 || a_rdata_o !== 32'(i + 1) || a_err_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got rvalid=%b rdata=%h err=%b required 1 %h 0", i, a_rvalid_o, a_rdata_o, a_err_o, 32'(i + 1));
      end
    end
    @(negedge clk);
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (a_rvalid_o !== 1'b0 || a_rdata_o !== 32'h3) begin
      n_fail++; $display("FAIL b2b_end: got rvalid=%b rdata=%h required 0 3", a_rvalid_o, a_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_a(1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (a_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_gnt: got %b required 1", a_gnt_o);
    end
    rstn_i = 1'b0;
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (a_rvalid_o !== 1'b0 || a_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_in_reset: got rvalid=%b rdata=%h required 0 0", a_rvalid_o, a_rdata_o);
    end
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, ram_en_o, ram_we_o, ram_be_o} !== 12'h0 ||
        a_rdata_o !== 32'h0 || b_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_after: got ctrl=%b a_rdata=%h b_rdata=%h required all 0",
                         {a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_err_o, b_err_o, ram_en_o, ram_we_o, ram_be_o}, a_rdata_o, b_rdata_o);
    end
    @(negedge clk);
    set_a(1'b1, 32'h0010_0100, 1'b0, 4'hF, 32'h0);
    set_b(1'b1, 32'h0010_0200, 1'b0, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (a_gnt_o !== 1'b1 || b_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_first_contention: got a=%b b=%b required a=1 b=0", a_gnt_o, b_gnt_o);
    end
    @(negedge clk);
    set_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_b(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_byte_write();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-master front-end for the single-port data RAM wrapper. Accepts PULP-style req/gnt/rvalid requests from port A (core LSU) and port B (AXI/debug bridge). Arbitrates them round-robin onto the RAM's en/we/be/addr/wdata interface and returns read data with a one-cycle response. Out-of-window addresses are rejected with an error response instead of aliasing into the RAM.

## Interface
Parameters:
- RAM_SIZE, 32768: RAM size in bytes, power of two.
- ADDR_WIDTH, $clog2(RAM_SIZE): byte-address width driven to the RAM.
- DATA_WIDTH, 32: data width.
- BASE_ADDR, 32'h0010_0000: RAM window base, aligned to RAM_SIZE.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rstn_i  in  1  asynchronous active-low reset.
- Master ports (x in {a, b}):
  - x_req_i  in  1  request.
  - x_gnt_o  out  1  grant, combinational, same cycle.
  - x_rvalid_o  out  1  response valid.
  - x_addr_i  in  32  byte address.
  - x_we_i  in  1  write enable.
  - x_be_i  in  DATA_WIDTH/8  byte enables.
  - x_wdata_i  in  DATA_WIDTH  write data.
  - x_rdata_o  out  DATA_WIDTH  read data.
  - x_err_o  out  1  error, valid with x_rvalid_o.
- RAM side:
  - ram_en_o  out  1  RAM enable.
  - ram_addr_o  out  ADDR_WIDTH  RAM byte address.
  - ram_we_o  out  1  RAM write enable.
  - ram_be_o  out  DATA_WIDTH/8  RAM byte enables.
  - ram_wdata_o  out  DATA_WIDTH  RAM write data.
  - ram_rdata_i  in  DATA_WIDTH  RAM read data, one cycle after en.
  - ram_bypass_en_o  out  1  tied 0.

## Operation
Arbitration:
- One grant per cycle at most.
- Only one port requesting: that port is granted.
- Both requesting: grant the port that is not last_gnt.
- last_gnt is a flop, updated to the granted port on every grant. Reset value = B, so A wins the first contention.

In-window request (x_addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]):
- In the grant cycle, drive ram_en_o=1, ram_addr_o=x_addr_i[ADDR_WIDTH-1:0], ram_we_o=x_we_i, ram_be_o=x_be_i, ram_wdata_o=x_wdata_i.
- addr[1:0] passes through unchanged; the RAM wrapper ignores it.

Out-of-window request:
- Grant is still given.
- ram_en_o stays 0; no RAM access.
- Response carries err=1 and rdata=0.

Response tracking:
- Per-port flops resp_vld and resp_err are set in the cycle after a grant.
- x_rvalid_o = resp_vld for both reads and writes.
- x_rdata_o during a read response = ram_rdata_i, or 0 on error. It is also captured into the per-port rdata_q.
- Outside response cycles, x_rdata_o = rdata_q (holds the last read value). Write responses do not update rdata_q.

Idle cycle (no grant): ram_en_o=0, ram_we_o=0, ram_be_o=0; ram_addr_o and ram_wdata_o are don't-care but driven from port A.

## Timing
- Grant: combinational from x_req_i in cycle N. The master must hold its request fields stable until granted.
- Response: x_rvalid_o (and x_err_o, x_rdata_o) is valid in cycle N+1, exactly one cycle after grant.
- Throughput: back-to-back grants every cycle, same or alternating ports. Full throughput, no bubbles.
- A port granted in N and again in N+1 gets rvalid in N+1 and N+2.
- Reset values: all x_gnt_o, x_rvalid_o, x_err_o, x_rdata_o, ram_en_o, ram_we_o and ram_be_o are 0; last_gnt = B.
- Reset asserted mid-transaction clears the pending resp_vld flags asynchronously. The response is lost and no rvalid appears after reset release.
- Request dropped before grant: no state change.

## Test plan
- Single read, A: write 0xDEADBEEF to 0x0010_0040 via A, then read 0x0010_0040 via A -> gnt same cycle, a_rvalid_o next cycle, a_rdata_o=0xDEADBEEF, a_err_o=0; rdata holds 0xDEADBEEF on the following idle cycles.
- Contention: A and B request every cycle for 4 cycles from reset -> grants A,B,A,B; each rvalid arrives on the matching port one cycle later.
- Byte write: B writes be=4'b0010, wdata=0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
- Out of window: A reads 0x0020_0000 -> a_gnt_o=1, ram_en_o=0, next cycle a_rvalid_o=1, a_err_o=1, a_rdata_o=0.
- Back-to-back: A issues 3 consecutive reads at 0x0010_0000, 0x0010_0004 and 0x0010_0008 (preloaded 1, 2, 3) -> rvalid for 3 consecutive cycles with data 1, 2, 3.
- Reset mid-op: grant a read in N, assert rstn_i=0 before the edge at N+1 -> no rvalid after release; all outputs 0; the first contention after release is granted to A.
